// File: rtl/vote_pkg.sv
// -----------------------------------------------------------------------------
// vote_pkg
// Shared definitions for the ballot front end (vote_input_conditioner) and the
// downstream votingMachine counter.
//   NUM_BUTTONS              number of candidate buttons
//   DEFAULT_DEBOUNCE_CYCLES  default stable-level filter length, in clocks
//   DEFAULT_LOCKOUT_CYCLES   default post-vote lockout length, in clocks
//   cand_idx_t               candidate index (0 = button1 .. 3 = button4)
//   state_t                  arbitration FSM states
//   encode_idx / to_onehot   conversions between one-hot and index form
// -----------------------------------------------------------------------------
package vote_pkg;

  localparam int NUM_BUTTONS             = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 10;
  localparam int DEFAULT_LOCKOUT_CYCLES  = 16;

  typedef logic [1:0] cand_idx_t;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    LOCKOUT      = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  // Index of the highest set bit. Only meaningful when exactly one bit is set.
  function automatic cand_idx_t encode_idx(input logic [NUM_BUTTONS-1:0] bits);
    cand_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (bits[i]) idx = cand_idx_t'(i);
    end
    return idx;
  endfunction

  function automatic logic [NUM_BUTTONS-1:0] to_onehot(input cand_idx_t idx);
    logic [NUM_BUTTONS-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Brings one asynchronous ballot button into the clock domain and filters it.
// The stable level db only follows the synchronised level after that level has
// differed from db on DEBOUNCE_CYCLES consecutive rising edges.
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   synchronous, active-high
//   raw    in   raw button level, asynchronous to clock
//   db     out  debounced stable level
// -----------------------------------------------------------------------------
module button_debounce
  import vote_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic db
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // NOTE: every register here uses <= so that sync1 -> sync2 -> db behave as a
  // true pipeline; a blocking = would let raw fall straight through in one edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      db    <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == db) begin
        // Any agreement restarts the run: the difference must be consecutive.
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // This edge would make the run DEBOUNCE_CYCLES long: accept the level.
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vote_input_conditioner.sv
// -----------------------------------------------------------------------------
// vote_input_conditioner
// Front end of the voting machine. Debounces the four ballot buttons and turns
// each accepted press into one single-cycle vote pulse. Simultaneous presses,
// presses in result mode and a button that is simply kept held never vote.
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high
//   mode         in   0 = voting, 1 = result mode (presses are swallowed)
//   button1..4   in   raw candidate buttons, asynchronous, active-high
//   vote_valid   out  one-cycle pulse per accepted vote
//   vote_sel     out  candidate index with vote_valid, else 0
//   vote_onehot  out  one-hot of vote_sel with vote_valid, else 0
//   multi_press  out  one-cycle pulse when a simultaneous press is rejected
//   busy         out  high whenever the arbiter is not in IDLE
// -----------------------------------------------------------------------------
module vote_input_conditioner
  import vote_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LOCKOUT_CYCLES  = DEFAULT_LOCKOUT_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       button4,
  output logic       vote_valid,
  output logic [1:0] vote_sel,
  output logic [3:0] vote_onehot,
  output logic       multi_press,
  output logic       busy
);

  localparam int CNT_W = $clog2(((DEBOUNCE_CYCLES > LOCKOUT_CYCLES) ?
                                 DEBOUNCE_CYCLES : LOCKOUT_CYCLES) + 1);

  logic [NUM_BUTTONS-1:0] raw;
  logic [NUM_BUTTONS-1:0] db;
  logic                   any_press;
  logic                   multi;
  state_t                 state;
  logic [CNT_W-1:0]       lock_cnt;

  assign raw = {button4, button3, button2, button1};

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock(clock),
      .reset(reset),
      .raw  (raw[i]),
      .db   (db[i])
    );
  end

  assign any_press = |db;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi     = (db & (db - NUM_BUTTONS'(1))) != '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      lock_cnt    <= '0;
      vote_valid  <= 1'b0;
      vote_sel    <= '0;
      vote_onehot <= '0;
      multi_press <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // Pulse outputs fall back to zero unless a branch below fires them.
      vote_valid  <= 1'b0;
      vote_sel    <= '0;
      vote_onehot <= '0;
      multi_press <= 1'b0;

      case (state)
        IDLE: begin
          if (any_press) begin
            busy <= 1'b1;
            if (mode) begin
              // Result mode: the press is consumed without any output.
              state <= WAIT_RELEASE;
            end else if (multi) begin
              multi_press <= 1'b1;
              state       <= WAIT_RELEASE;
            end else begin
              vote_valid  <= 1'b1;
              vote_sel    <= encode_idx(db);
              vote_onehot <= to_onehot(encode_idx(db));
              lock_cnt    <= CNT_W'(LOCKOUT_CYCLES - 1);
              state       <= LOCKOUT;
            end
          end
        end

        LOCKOUT: begin
          if (lock_cnt == '0) begin
            state <= WAIT_RELEASE;
          end else begin
            lock_cnt <= lock_cnt - CNT_W'(1);
          end
        end

        WAIT_RELEASE: begin
          // Only a full release re-arms voting, so a held button votes once.
          if (!any_press) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
